muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the HI/LO arithmetic path.
- Accepts one MUL or DIV request at a time under a start/busy/done handshake and registers the operands.
- MUL: drives the operands to the external combinational Booth radix-4 multiplier, waits a fixed multicycle window, then captures its 64-bit product.
- DIV: runs an internal 32-iteration signed restoring divider. In both cases the result goes into HI/LO with a one-cycle write-enable pulse.

Parameters:
- MUL_CYCLES, 2, edges the multiplier operands are held stable before the product is captured; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  2  operation: 00 = MUL (signed), 01 = DIV (signed); 10 and 11 are illegal.
- a  in  32  multiplicand / dividend.
- b  in  32  multiplier / divisor.
- mul_result  in  64  product returned by the external multiplier.
- mul_a  out  32  multiplier operand A (registered).
- mul_b  out  32  multiplier operand B (registered).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- hilo_we  out  1  HI/LO write enable; identical to done.
- hi  out  32  MUL: product[63:32]; DIV: remainder.
- lo  out  32  MUL: product[31:0]; DIV: quotient.
- div_by_zero  out  1  sticky flag for the last operation; updated at each capture.

Behaviour:
- Reset (async, clear=1):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, hilo_we, hi, lo, mul_a, mul_b, div_by_zero.
  - Counters and internal divider registers go to 0.
  - Reset mid-operation abandons the operation; no hilo_we is issued for it.
- States: IDLE, MUL_WAIT, DIV_PREP, DIV_ITER, DIV_FIX, DONE.
- Acceptance, at edge E0:
  - Requires state IDLE and start=1 with a legal op.
  - a and b are latched; busy rises after E0.
  - start with an illegal op is ignored (stay IDLE, no done).
  - start while busy (including the DONE cycle) is ignored; no queuing.
- MUL path:
  - At E0: mul_a <= a, mul_b <= b, counter <= MUL_CYCLES-1, state goes to MUL_WAIT.
  - Each edge decrements the counter. The edge on which the counter is 0 captures {hi,lo} <= mul_result, sets div_by_zero <= 0 and moves to DONE.
  - The capture edge is E0+MUL_CYCLES.
  - mul_a/mul_b hold their values until the next accepted MUL; DIV does not modify them.
- DIV path:
  - Signed operands, quotient truncates toward zero, remainder takes the dividend's sign.
  - E1 (DIV_PREP):
    - If b==0: hi <= a, lo <= 32'hFFFFFFFF, div_by_zero <= 1, go to DONE (capture at E1).
    - Otherwise: compute |a| and |b|, record the result signs, clear the 33-bit partial remainder, iteration counter <= 31, go to DIV_ITER.
  - DIV_ITER, one edge per iteration, 32 edges (E2..E33):
    - Shift {rem, quotient} left by 1 and trial-subtract |b|.
    - If non-negative, keep the difference and set quotient bit 0 = 1; otherwise restore.
    - Leave DIV_ITER for DIV_FIX when the counter reaches 0.
  - E34 (DIV_FIX): apply the signs, capture hi <= remainder and lo <= quotient, div_by_zero <= 0, go to DONE.
  - Overflow case 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural 32-bit wrap; no flag).
- DONE:
  - Lasts exactly one cycle; done=hilo_we=1 and busy=1.
  - Next edge goes to IDLE.
  - The earliest next acceptance is the edge after that.
- hi/lo change only on capture edges and hold between operations.
- Latency, capture edge to DONE: MUL = MUL_CYCLES edges after E0; DIV = 34 edges; DIV by zero = 1 edge.

Test Plan:
- MUL_CYCLES=2, op=00, a=7, b=0xFFFFFFFD:
  - mul_a/mul_b = 7 / 0xFFFFFFFD after E0.
  - done one cycle after E2.
  - {hi,lo} = 0xFFFFFFFF_FFFFFFEB.
  - busy high E0..DONE.
- op=00, a=b=0x80000000 -> {hi,lo} = 0x40000000_00000000; div_by_zero=0.
- op=01, a=0xFFFFFFEF (-17), b=5:
  - done after E34.
  - lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFE (-2).
  - hilo_we asserted exactly one cycle.
- op=01, a=10, b=0 -> done after E1; hi=10, lo=0xFFFFFFFF, div_by_zero=1.
- Follow the divide-by-zero case with a MUL; div_by_zero must return to 0.
- op=01, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake and reset:
  - Pulse start at E5 of a DIV; it must be ignored.
  - Pulse start with op=10 in IDLE; it must be ignored, with no busy.
  - Assert clear at E20 of a DIV: all outputs 0 immediately, no done, and the next start is accepted normally.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle for the HI/LO multiply/divide sequencer, including
// the operand/product link to the external Booth multiplier.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] mul_result;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        busy;
    logic        done;
    logic        hilo_we;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    // Requester side: issues operations and returns the multiplier product
    modport master (
        output start, op, a, b, mul_result,
        input  mul_a, mul_b, busy, done, hilo_we, hi, lo, div_by_zero
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b, mul_result,
        output mul_a, mul_b, busy, done, hilo_we, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO controller: signed MUL via an external combinational
// multiplier with a fixed wait window, signed DIV via an internal 32-step
// restoring divider. Results land in HI/LO with a one-cycle write pulse.
module muldiv_sequencer #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic               clock,
    input  logic               clear,
    muldiv_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_DIV_PREP,
        S_DIV_ITER,
        S_DIV_FIX,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_DIV = 2'b01
    } op_t;

    state_t      state, next_state;
    logic [4:0]  cnt;
    logic [31:0] a_r, b_r;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        neg_q, neg_r;
    logic [31:0] hi_r, lo_r, mul_a_r, mul_b_r;
    logic        dz_r;
    logic        busy_c, done_c;
    logic        accept;

    logic [31:0] a_abs, b_abs;
    logic [32:0] shifted, diff;

    assign accept = (state == S_IDLE) && bus.start &&
                    (bus.op == OP_MUL || bus.op == OP_DIV);

    // Divider helpers: operand magnitudes and one shift/trial-subtract step
    always_comb begin
        a_abs   = a_r[31] ? (~a_r + 32'd1) : a_r;
        b_abs   = b_r[31] ? (~b_r + 32'd1) : b_r;
        shifted = {rem[31:0], quo[31]};
        diff    = shifted - {1'b0, divisor};
    end

    // State register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (accept)
                    next_state = (bus.op == OP_MUL) ? S_MUL_WAIT : S_DIV_PREP;
            end
            S_MUL_WAIT: if (cnt == '0) next_state = S_DONE;
            S_DIV_PREP: next_state = (b_r == '0) ? S_DONE : S_DIV_ITER;
            S_DIV_ITER: if (cnt == '0) next_state = S_DIV_FIX;
            S_DIV_FIX:  next_state = S_DONE;
            S_DONE: begin
                done_c     = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                busy_c     = 1'b0;
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand latching, wait/iteration counter, divider datapath and HI/LO capture
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            mul_a_r <= '0;
            mul_b_r <= '0;
            dz_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_r <= bus.a;
                        b_r <= bus.b;
                        if (bus.op == OP_MUL) begin
                            mul_a_r <= bus.a;
                            mul_b_r <= bus.b;
                            cnt     <= 5'(MUL_CYCLES - 1);
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (cnt == '0) begin
                        {hi_r, lo_r} <= bus.mul_result;
                        dz_r         <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                S_DIV_PREP: begin
                    if (b_r == '0) begin
                        hi_r <= a_r;
                        lo_r <= '1;
                        dz_r <= 1'b1;
                    end else begin
                        rem     <= '0;
                        quo     <= a_abs;
                        divisor <= b_abs;
                        neg_q   <= a_r[31] ^ b_r[31];
                        neg_r   <= a_r[31];
                        cnt     <= 5'd31;
                    end
                end
                S_DIV_ITER: begin
                    // quo doubles as the dividend shift register: its MSB feeds
                    // the remainder while result bits enter at the LSB.
                    if (!diff[32]) begin
                        rem <= diff;
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                end
                S_DIV_FIX: begin
                    lo_r <= neg_q ? (~quo + 32'd1) : quo;
                    hi_r <= neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];
                    dz_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_c;
    assign bus.done        = done_c;
    assign bus.hilo_we     = done_c;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.mul_a       = mul_a_r;
    assign bus.mul_b       = mul_b_r;
    assign bus.div_by_zero = dz_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: MUL/DIV results, latencies,
// handshake rejection cases and asynchronous reset mid-operation.
module tb_muldiv_sequencer;

    logic clock;
    logic clear;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned n_fail;
    int unsigned cyc;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.MUL_CYCLES(2)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    // Behavioural stand-in for the external signed multiplier
    assign bus.mul_result = $signed({{32{bus.mul_a[31]}}, bus.mul_a}) *
                            $signed({{32{bus.mul_b[31]}}, bus.mul_b});

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one request across edge E0; returns at E0+1
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts edges after E0 until done is seen, bounded by limit
    task automatic wait_done(input int unsigned from, input int unsigned limit, output int unsigned n);
        n = from;
        while (bus.done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        clear     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mulab", {bus.mul_a, bus.mul_b}, 64'd0);
        chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
        clear = 1'b0;
        tick();

        // MUL 7 * -3
        start_op(2'b00, 32'd7, 32'hFFFFFFFD);
        chk("mul1_mul_a", 64'(bus.mul_a), 64'd7);
        chk("mul1_mul_b", 64'(bus.mul_b), 64'hFFFFFFFD);
        chk("mul1_busy_e0", 64'(bus.busy), 64'd1);
        chk("mul1_done_e0", 64'(bus.done), 64'd0);
        wait_done(0, 100, cyc);
        chk("mul1_latency", 64'(cyc), 64'd2);
        chk("mul1_hilo", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        chk("mul1_we", 64'(bus.hilo_we), 64'd1);
        chk("mul1_busy_done", 64'(bus.busy), 64'd1);
        chk("mul1_dz", 64'(bus.div_by_zero), 64'd0);
        tick();
        chk("mul1_done_after", 64'(bus.done), 64'd0);
        chk("mul1_busy_after", 64'(bus.busy), 64'd0);

        // MUL min * min
        start_op(2'b00, 32'h80000000, 32'h80000000);
        wait_done(0, 100, cyc);
        chk("mul2_latency", 64'(cyc), 64'd2);
        chk("mul2_hilo", {bus.hi, bus.lo}, 64'h40000000_00000000);
        chk("mul2_dz", 64'(bus.div_by_zero), 64'd0);
        tick();

        // DIV -17 / 5
        start_op(2'b01, 32'hFFFFFFEF, 32'd5);
        wait_done(0, 100, cyc);
        chk("div1_latency", 64'(cyc), 64'd34);
        chk("div1_lo", 64'(bus.lo), 64'hFFFFFFFD);
        chk("div1_hi", 64'(bus.hi), 64'hFFFFFFFE);
        chk("div1_we", 64'(bus.hilo_we), 64'd1);
        tick();
        chk("div1_we_once", 64'(bus.hilo_we), 64'd0);
        chk("div1_mul_a_kept", 64'(bus.mul_a), 64'h80000000);

        // DIV 10 / 0
        start_op(2'b01, 32'd10, 32'd0);
        wait_done(0, 100, cyc);
        chk("dbz_latency", 64'(cyc), 64'd1);
        chk("dbz_hi", 64'(bus.hi), 64'd10);
        chk("dbz_lo", 64'(bus.lo), 64'hFFFFFFFF);
        chk("dbz_flag", 64'(bus.div_by_zero), 64'd1);
        tick();

        // MUL after divide-by-zero clears the flag
        start_op(2'b00, 32'd3, 32'd4);
        wait_done(0, 100, cyc);
        chk("mul3_latency", 64'(cyc), 64'd2);
        chk("mul3_hilo", {bus.hi, bus.lo}, 64'd12);
        chk("mul3_dz", 64'(bus.div_by_zero), 64'd0);
        tick();

        // DIV overflow wraps
        start_op(2'b01, 32'h80000000, 32'hFFFFFFFF);
        wait_done(0, 100, cyc);
        chk("ovf_latency", 64'(cyc), 64'd34);
        chk("ovf_lo", 64'(bus.lo), 64'h80000000);
        chk("ovf_hi", 64'(bus.hi), 64'd0);
        tick();

        // DIV 7 / -2, with a start attempted during DONE
        start_op(2'b01, 32'd7, 32'hFFFFFFFE);
        wait_done(0, 100, cyc);
        chk("div2_lo", 64'(bus.lo), 64'hFFFFFFFD);
        chk("div2_hi", 64'(bus.hi), 64'd1);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        tick();
        bus.start = 1'b0;
        chk("done_start_busy", 64'(bus.busy), 64'd0);
        chk("done_start_mul_a", 64'(bus.mul_a), 64'd3);
        tick();

        // DIV 1000 / 10 with a start pulse at E5
        start_op(2'b01, 32'd1000, 32'd10);
        repeat (4) tick();
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        tick();
        bus.start = 1'b0;
        wait_done(5, 100, cyc);
        chk("div3_latency", 64'(cyc), 64'd34);
        chk("div3_lo", 64'(bus.lo), 64'd100);
        chk("div3_hi", 64'(bus.hi), 64'd0);
        chk("div3_mul_a", 64'(bus.mul_a), 64'd3);
        tick();

        // Illegal ops in IDLE
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        tick();
        chk("ill10_busy", 64'(bus.busy), 64'd0);
        bus.op = 2'b11;
        tick();
        bus.start = 1'b0;
        chk("ill11_busy", 64'(bus.busy), 64'd0);
        tick();
        chk("ill_done", 64'(bus.done), 64'd0);
        chk("ill_hilo_held", {bus.hi, bus.lo}, 64'd100);

        // Asynchronous reset at E20 of a DIV
        start_op(2'b01, 32'd100, 32'd7);
        repeat (19) tick();
        @(posedge clock);
        #2;
        clear = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_we", 64'(bus.hilo_we), 64'd0);
        chk("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("arst_mulab", {bus.mul_a, bus.mul_b}, 64'd0);
        chk("arst_dz", 64'(bus.div_by_zero), 64'd0);
        tick();
        clear = 1'b0;
        tick();
        chk("arst_no_done", 64'(bus.done), 64'd0);
        chk("arst_idle", 64'(bus.busy), 64'd0);

        // First request after reset
        start_op(2'b00, 32'd6, 32'd7);
        chk("post_busy", 64'(bus.busy), 64'd1);
        wait_done(0, 100, cyc);
        chk("post_latency", 64'(cyc), 64'd2);
        chk("post_hilo", {bus.hi, bus.lo}, 64'd42);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
